// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared types and constants for the CPU front end.
//
// Holds the instruction-cache address split, the fill-controller state
// encoding and the default cache geometry used by icache_fill_ctrl and
// icache_array.
package cpu_types_pkg;

  localparam int ICACHE_SETS = 8;
  localparam int IBLKOFF_W   = 1;
  localparam int ICACHE_IDXW = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAGW = 32 - 3 - ICACHE_IDXW;

  // Field view of a fetch address at the default geometry.
  typedef struct packed {
    logic [ICACHE_TAGW-1:0] tag;
    logic [ICACHE_IDXW-1:0] idx;
    logic [IBLKOFF_W-1:0]   blkoff;
    logic [1:0]             bytoff;
  } icachef_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH0,
    FETCH1
  } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// icache_array -- valid/tag/data storage for the direct-mapped icache.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears valids)
//   flush             clears every valid bit at the edge; beats a write
//   rdidx             set index for the combinational read port
//   rdvalid/rdtag     valid bit and stored tag of the selected set
//   rdword0/rdword1   the two words of the selected set
//   wren, wridx       single-set write enable and target set
//   wrtag, wrword0/1  tag and data installed on a write (valid set to 1)
module icache_array
  import cpu_types_pkg::*;
#(
  parameter int SETS = ICACHE_SETS,
  parameter int IDXW = $clog2(SETS),
  parameter int TAGW = 32 - 3 - IDXW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [IDXW-1:0] rdidx,
  output logic            rdvalid,
  output logic [TAGW-1:0] rdtag,
  output logic [31:0]     rdword0,
  output logic [31:0]     rdword1,
  input  logic            wren,
  input  logic [IDXW-1:0] wridx,
  input  logic [TAGW-1:0] wrtag,
  input  logic [31:0]     wrword0,
  input  logic [31:0]     wrword1
);

  logic [SETS-1:0] valid;
  logic [TAGW-1:0] tags   [SETS];
  logic [31:0]     words0 [SETS];
  logic [31:0]     words1 [SETS];

  // Valid bits: reset and flush clear all sets and take priority over a
  // completing fill, so a flushed line can never be left valid.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= '0;
    end else if (wren) begin
      valid[wridx] <= 1'b1;
    end
  end

  // Tag and data need no reset; they are only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (wren) begin
      tags[wridx]   <= wrtag;
      words0[wridx] <= wrword0;
      words1[wridx] <= wrword1;
    end
  end

  assign rdvalid = valid[rdidx];
  assign rdtag   = tags[rdidx];
  assign rdword0 = words0[rdidx];
  assign rdword1 = words1[rdidx];

endmodule

// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl -- direct-mapped, 2-word-block instruction cache with
// line-fill sequencing toward the memory controller's instruction port.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   imemREN, imemaddr   fetch request and byte address from the datapath
//   ihit, imemload      hit this cycle and the instruction word (0 on miss)
//   iflush              invalidate all lines, abort any fill in progress
//   iREN, iaddr         read request / word address to the controller
//   iwait, iload        controller busy flag and returned word
//   hitcnt, misscnt     saturating statistics (only with ICACHE_STATS_EN)
//
// Build option: define ICACHE_STATS_EN to add the hit/miss counters.
module icache_fill_ctrl
  import cpu_types_pkg::*;
#(
  parameter int SETS = ICACHE_SETS
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iflush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hitcnt,
  output logic [31:0] misscnt,
`endif
  input  logic [31:0] iload
);

  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 32 - 3 - IDXW;

  icache_state_t   state, nextstate;
  logic [TAGW-1:0] filltag;
  logic [IDXW-1:0] fillidx;
  logic [31:0]     fillbuf;

  logic [TAGW-1:0] reqtag;
  logic [IDXW-1:0] reqidx;
  logic            reqblk;
  logic            rdvalid;
  logic [TAGW-1:0] rdtag;
  logic [31:0]     rdword0, rdword1;
  logic            wren;
  logic            startmiss;
  logic            capture0;
  logic            unused_byteoff;

  assign reqtag         = imemaddr[31:3+IDXW];
  assign reqidx         = imemaddr[2+IDXW:3];
  assign reqblk         = imemaddr[2];
  assign unused_byteoff = &{1'b0, imemaddr[1:0]};

  icache_array #(
    .SETS (SETS),
    .IDXW (IDXW),
    .TAGW (TAGW)
  ) u_array (
    .clk     (CLK),
    .rst     (RST),
    .flush   (iflush),
    .rdidx   (reqidx),
    .rdvalid (rdvalid),
    .rdtag   (rdtag),
    .rdword0 (rdword0),
    .rdword1 (rdword1),
    .wren    (wren),
    .wridx   (fillidx),
    .wrtag   (filltag),
    .wrword0 (fillbuf),
    .wrword1 (iload)
  );

  // State register plus the fill register: the missing tag/index is latched
  // when the fill starts so later address changes cannot redirect it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      filltag <= '0;
      fillidx <= '0;
      fillbuf <= '0;
    end else begin
      state <= nextstate;
      if (startmiss) begin
        filltag <= reqtag;
        fillidx <= reqidx;
      end
      if (capture0) begin
        fillbuf <= iload;
      end
    end
  end

  // Next-state and outputs. Hits are only served in IDLE; during a fill the
  // controller sees a stable word address and the datapath sees ihit=0.
  // A flush aborts the fill without writing the line.
  always_comb begin
    nextstate = state;
    ihit      = 1'b0;
    imemload  = '0;
    iREN      = 1'b0;
    iaddr     = '0;
    wren      = 1'b0;
    startmiss = 1'b0;
    capture0  = 1'b0;
    case (state)
      IDLE: begin
        ihit = imemREN && rdvalid && (rdtag == reqtag) && !iflush;
        if (ihit) begin
          imemload = reqblk ? rdword1 : rdword0;
        end else if (imemREN) begin
          startmiss = 1'b1;
          nextstate = FETCH0;
        end
      end
      FETCH0: begin
        iREN  = 1'b1;
        iaddr = {filltag, fillidx, 3'b000};
        if (iflush) begin
          nextstate = IDLE;
        end else if (!iwait) begin
          capture0  = 1'b1;
          nextstate = FETCH1;
        end
      end
      FETCH1: begin
        iREN  = 1'b1;
        iaddr = {filltag, fillidx, 3'b100};
        if (iflush) begin
          nextstate = IDLE;
        end else if (!iwait) begin
          wren      = 1'b1;
          nextstate = IDLE;
        end
      end
      default: begin
        nextstate = IDLE;
      end
    endcase
  end

`ifdef ICACHE_STATS_EN
  // Saturating hit/miss counters; cleared only by reset, not by flush.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hitcnt  <= '0;
      misscnt <= '0;
    end else begin
      if (ihit && (hitcnt != 32'hFFFF_FFFF)) begin
        hitcnt <= hitcnt + 32'd1;
      end
      if (startmiss && (misscnt != 32'hFFFF_FFFF)) begin
        misscnt <= misscnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb_icache_fill_ctrl -- directed self-checking bench for icache_fill_ctrl.
//
// Drives inputs 1 ns after each rising edge and samples 1 ns later, well
// away from the active edge. Expected values are hand-derived from the
// address split: [31:6] tag, [5:3] index, [2] block offset.
module tb_icache_fill_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iflush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hitcnt;
  logic [31:0] misscnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  icache_fill_ctrl dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iflush   (iflush),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
`ifdef ICACHE_STATS_EN
    .hitcnt   (hitcnt),
    .misscnt  (misscnt),
`endif
    .iload    (iload)
  );

  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive every input, then let combinational outputs settle.
  task automatic applyStimulus(input logic rst, input logic ren,
                               input logic [31:0] addr, input logic wt,
                               input logic [31:0] load, input logic fl);
    RST      = rst;
    imemREN  = ren;
    imemaddr = addr;
    iwait    = wt;
    iload    = load;
    iflush   = fl;
    #1;
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic exphit,
                             input logic [31:0] expload, input logic expiren,
                             input logic [31:0] expiaddr);
    checkBit({tag, ".ihit"}, ihit, exphit);
    checkWord({tag, ".imemload"}, imemload, expload);
    checkBit({tag, ".iREN"}, iREN, expiren);
    checkWord({tag, ".iaddr"}, iaddr, expiaddr);
  endtask

  // Zero-wait fill starting from IDLE with a miss on addr; leaves the
  // controller back in IDLE with the line installed.
  task automatic doFill(input string tag, input logic [31:0] addr,
                        input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] base;
    base = {addr[31:3], 3'b000};
    applyStimulus(1'b0, 1'b1, addr, 1'b0, w0, 1'b0);
    checkOutput({tag, ".miss"}, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b1, addr, 1'b0, w0, 1'b0);
    checkOutput({tag, ".f0"}, 1'b0, 32'h0, 1'b1, base);
    tick();
    applyStimulus(1'b0, 1'b1, addr, 1'b0, w1, 1'b0);
    checkOutput({tag, ".f1"}, 1'b0, 32'h0, 1'b1, base | 32'h4);
    tick();
  endtask

  initial begin
    $display("[TB] start");
    // Reset and idle outputs.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("reset", 1'b0, 32'h0, 1'b0, 32'h0);

    // First fill of 0x40, hit three edges after the request.
    doFill("fill40", 32'h40, 32'h1111_1111, 32'h2222_2222);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    checkOutput("hit40", 1'b1, 32'h1111_1111, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h44, 1'b0, 32'h0, 1'b0);
    checkOutput("hit44", 1'b1, 32'h2222_2222, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h47, 1'b0, 32'h0, 1'b0);
    checkOutput("hit47_byteoff", 1'b1, 32'h2222_2222, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h40, 1'b0, 32'h0, 1'b0);
    checkOutput("noreq40", 1'b0, 32'h0, 1'b0, 32'h0);

    // Miss at 0x80 with four wait cycles per word; the fetch address is
    // moved to 0x40 while waiting and must not redirect the fill.
    applyStimulus(1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
    checkOutput("miss80", 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 32'hDEAD_BEEF, 1'b0);
      checkOutput("wait80_f0", 1'b0, 32'h0, 1'b1, 32'h80);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 32'hAAAA_0000, 1'b0);
    checkOutput("done80_f0", 1'b0, 32'h0, 1'b1, 32'h80);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 32'hDEAD_BEEF, 1'b0);
      checkOutput("wait80_f1", 1'b0, 32'h0, 1'b1, 32'h84);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 32'hBBBB_1111, 1'b0);
    checkOutput("done80_f1", 1'b0, 32'h0, 1'b1, 32'h84);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
    checkOutput("hit80", 1'b1, 32'hAAAA_0000, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h84, 1'b0, 32'h0, 1'b0);
    checkOutput("hit84", 1'b1, 32'hBBBB_1111, 1'b0, 32'h0);

    // 0x80 shares index 0 with 0x40, so 0x40 was evicted: refill it, then
    // evict it again with 0x240 (same index, tag 9).
    doFill("refill40", 32'h40, 32'h1111_1111, 32'h2222_2222);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    checkOutput("rehit40", 1'b1, 32'h1111_1111, 1'b0, 32'h0);
    doFill("fill240", 32'h240, 32'h3333_3333, 32'h4444_4444);
    applyStimulus(1'b0, 1'b1, 32'h244, 1'b0, 32'h0, 1'b0);
    checkOutput("hit244", 1'b1, 32'h4444_4444, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    checkOutput("evicted40", 1'b0, 32'h0, 1'b0, 32'h0);

    // A different index is independent of index 0.
    doFill("fill48", 32'h48, 32'h5555_5555, 32'h6666_6666);
    applyStimulus(1'b0, 1'b1, 32'h4C, 1'b0, 32'h0, 1'b0);
    checkOutput("hit4C", 1'b1, 32'h6666_6666, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h240, 1'b0, 32'h0, 1'b0);
    checkOutput("still240", 1'b1, 32'h3333_3333, 1'b0, 32'h0);

    // iflush forces ihit low combinationally and clears the cache.
    applyStimulus(1'b0, 1'b1, 32'h48, 1'b0, 32'h0, 1'b1);
    checkOutput("flushcomb48", 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h48, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h48, 1'b0, 32'h0, 1'b0);
    checkOutput("flushed48", 1'b0, 32'h0, 1'b0, 32'h0);

    // iflush in FETCH1 while the controller is still busy aborts the fill.
    tick();
    applyStimulus(1'b0, 1'b1, 32'h48, 1'b0, 32'h5555_5555, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h48, 1'b1, 32'h6666_6666, 1'b1);
    checkOutput("flushf1", 1'b0, 32'h0, 1'b1, 32'h4C);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h48, 1'b0, 32'h0, 1'b0);
    checkOutput("abortidle", 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h48, 1'b0, 32'h0, 1'b0);
    checkOutput("abortmiss48", 1'b0, 32'h0, 1'b0, 32'h0);

    // Flush coinciding with fill completion: flush wins, line not valid.
    tick();
    applyStimulus(1'b0, 1'b1, 32'h48, 1'b0, 32'h5555_5555, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h48, 1'b0, 32'h6666_6666, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h48, 1'b0, 32'h0, 1'b0);
    checkOutput("flushwins48", 1'b0, 32'h0, 1'b0, 32'h0);

    // Install 0x48, then reset in the middle of a 0x240 fill.
    doFill("fill48b", 32'h48, 32'h5555_5555, 32'h6666_6666);
    applyStimulus(1'b0, 1'b1, 32'h48, 1'b0, 32'h0, 1'b0);
    checkOutput("hit48b", 1'b1, 32'h5555_5555, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h240, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h240, 1'b0, 32'h7777_7777, 1'b0);
    checkOutput("f0prereset", 1'b0, 32'h0, 1'b1, 32'h240);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h240, 1'b0, 32'h0, 1'b0);
    checkOutput("midreset", 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef ICACHE_STATS_EN
    checkWord("hitcnt.reset", hitcnt, 32'd0);
    checkWord("misscnt.reset", misscnt, 32'd0);
`endif

    // 0x48 was lost by the reset: one miss, then five hit cycles.
    doFill("fill48c", 32'h48, 32'h5555_5555, 32'h6666_6666);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h48, 1'b0, 32'h0, 1'b0);
      checkOutput("hit48c", 1'b1, 32'h5555_5555, 1'b0, 32'h0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 32'h48, 1'b0, 32'h0, 1'b0);
    checkOutput("idleend", 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef ICACHE_STATS_EN
    checkWord("hitcnt", hitcnt, 32'd5);
    checkWord("misscnt", misscnt, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
- Direct-mapped, 2-word-block instruction cache that feeds the instruction port of the memory controller (iREN/iaddr in, iwait/iload out).
- Serves fetch-stage requests on hit in the same cycle.
- On miss, sequences a two-word line fill through the controller's wait handshake, then serves the hit.
- Sits between the CPU fetch stage and the RAM arbiter.

Parameters:
- SETS, 8, number of lines; power of two; index width IDXW = log2(SETS).
- TAGW, 32-3-IDXW (26 at default), tag width derived from the address split.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- imemREN  input  1  fetch request from datapath.
- imemaddr  input  32  fetch byte address; bits [1:0] ignored.
- ihit  output  1  requested word valid this cycle.
- imemload  output  32  instruction word; 0 when ihit=0.
- iflush  input  1  invalidate all lines.
- iREN  output  1  read request to the memory controller.
- iaddr  output  32  word address to the memory controller.
- iwait  input  1  controller busy; a word is returned in a cycle with iREN=1 and iwait=0.
- iload  input  32  returned word.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Address split: [1:0] byte offset, [2] block offset, [2+IDXW:3] index, [31:3+IDXW] tag.
- Storage per set: valid bit, TAGW tag, two 32-bit words.
- Reset (RST=1 at a CLK edge):
  - All valid bits = 0; state = IDLE; fill buffer = 0.
  - Outputs the following cycle: ihit=0, imemload=0, iREN=0, iaddr=0.
  - Reset mid-fill abandons the fill; no line is written.
- FSM state IDLE:
  - ihit = imemREN & valid[idx] & (tag==stored tag), combinational, zero-latency.
  - imemload = word[blkoff] on hit, else 0.
  - Miss with imemREN=1: latch tag/idx into the fill register and go to FETCH0.
  - iREN=0 in this state.
- FSM state FETCH0:
  - iREN=1; iaddr = {filltag, fillidx, 3'b000}; ihit=0.
  - When iwait=0: capture iload into buffer word0, go to FETCH1.
- FSM state FETCH1:
  - iREN=1; iaddr = {filltag, fillidx, 3'b100}; ihit=0.
  - When iwait=0: write word0, iload, tag, and valid=1 to the set; go to IDLE.
- Latency: with zero controller wait, a miss delivers ihit 3 cycles after the request edge. Each iwait=1 cycle adds one cycle.
- Fill uses latched tag/idx. Changes to imemaddr or imemREN during a fill do not redirect or abort it; the line is still installed.
- In IDLE, the re-evaluated address may then hit or start a new miss.
- iflush:
  - Clears all valid bits at the edge.
  - In FETCH0/FETCH1, it also aborts the fill: returns to IDLE with iREN=0 next cycle and no write.
  - iflush=1 forces ihit=0 combinationally.
  - Simultaneous iflush and fill completion: flush wins and the line is not left valid.
- Conflict eviction: a fill to an occupied set overwrites it; there is no write-back (instruction data is read-only).
- iaddr is 0 whenever iREN=0.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - Adds outputs hitcnt[31:0] and misscnt[31:0].
  - hitcnt increments on each IDLE cycle with ihit=1.
  - misscnt increments on each IDLE→FETCH0 transition.
  - Both clear on RST, saturate at 32'hFFFFFFFF, and are unaffected by iflush.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- cpu_types_pkg additions:
  - icachef_t packed struct {tag, idx, blkoff, bytoff} for the address split.
  - icache_state_t enum {IDLE, FETCH0, FETCH1}.
  - Constants ICACHE_SETS=8, IBLKOFF_W=1.
- One sub-module, icache_array: valid/tag/data storage with a combinational read port, single-set write port, and flash-clear.
- The FSM remains in icache_fill_ctrl.

Test Plan:
- Reset, then imemREN=1, imemaddr=0x00000040, iwait=0, iload=0x11111111 then 0x22222222 → iREN/iaddr = 0x40 then 0x44; ihit=1, imemload=0x11111111 three cycles after request.
- Same line, imemaddr=0x00000044 → ihit=1 the same cycle with imemload=0x22222222 and iREN stays 0.
- Miss at 0x00000080 with iwait=1 for 4 cycles per word → iREN held at 1 and iaddr stable (0x80, then 0x84); ihit=0 throughout; fill completes 8 cycles later than the zero-wait case.
- After filling 0x40, access 0x00000240 (same idx, different tag) → miss, refill; a subsequent 0x40 misses again.
- iflush asserted in FETCH1 → next cycle iREN=0, state IDLE; re-request of 0x40 misses.
- RST asserted in FETCH0 → next cycle all outputs 0; prior valid lines miss. With ICACHE_STATS_EN: 1 miss + 5 hits gives misscnt=1, hitcnt=5.
